write_line_buffer: RTL and testbench

WRITE_LINE_BUFFER -- requirements
Module: write_line_buffer

---
 rtl/write_line_buffer_pkg.sv | 15 +
 rtl/write_line_buffer_fifo.sv | 51 +++++
 rtl/write_line_buffer.sv | 110 +++++++++++
 tb/tb_write_line_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_line_buffer_pkg.sv
// Shared widths and FSM encoding for the write line buffer.
package write_line_buffer_pkg;
  localparam int WORD_W         = 64;
  localparam int LINE_W         = 512;
  localparam int WORDS_PER_LINE = 8;
  localparam int LINE_CNT_W     = 9;
  localparam int WORD_CNT_W     = 3;
  localparam int ENTRY_W        = LINE_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/write_line_buffer_fifo.sv
// Synchronous line FIFO; a push into a full FIFO is taken only with a pop.
module line_fifo #(
  parameter int WIDTH = 514,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/write_line_buffer.sv
// Packs 64-bit result words into 512-bit lines and queues them
module write_line_buffer
  import write_line_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start_i,
  input  logic [LINE_CNT_W-1:0] FrameLines_i,
  input  logic [WORD_W-1:0]     DataIn_i,
  input  logic                  DataValid_i,
  output logic                  DataReady_o,
  output logic [LINE_W-1:0]     WriteBuffer_o,
  output logic                  WriteReq_o,
  input  logic                  WriteAck_i,
  output logic                  First_o,
  output logic                  Last_o,
  output logic                  Busy_o
);
  localparam int BUF_W = LINE_W - WORD_W;

  state_t                r_state;
  logic [WORD_CNT_W-1:0] r_word_cnt;
  logic [LINE_CNT_W-1:0] r_line_cnt;
  logic [LINE_CNT_W-1:0] r_frame_lines;
  logic [BUF_W-1:0]      r_line_buf;

  logic               w_accept;
  logic               w_line_done;
  logic               w_first;
  logic               w_last;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;

  assign DataReady_o = (r_state == ST_RUN)
                     & ~((r_word_cnt == 3'd7) & w_full);
  assign w_accept    = DataValid_i & DataReady_o;
  assign w_line_done = w_accept & (r_word_cnt == 3'd7);
  assign w_first     = (r_line_cnt == '0);
  assign w_last      = (r_line_cnt == r_frame_lines - 1'b1);
  // Word 7 bypasses the buffer and completes the line directly.
  assign w_push_data = {w_last, w_first, DataIn_i, r_line_buf};

  assign WriteReq_o    = ~w_empty;
  assign w_pop         = WriteReq_o & WriteAck_i;
  assign WriteBuffer_o = w_empty ? '0 : w_head[LINE_W-1:0];
  assign First_o       = ~w_empty & w_head[LINE_W];
  assign Last_o        = ~w_empty & w_head[LINE_W+1];
  assign Busy_o        = (r_state != ST_IDLE);

  line_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_line_done),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_word_cnt    <= '0;
      r_line_cnt    <= '0;
      r_frame_lines <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (Start_i && FrameLines_i != '0) begin
            r_frame_lines <= FrameLines_i;
            r_word_cnt    <= '0;
            r_line_cnt    <= '0;
            r_state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_accept) r_word_cnt <= r_word_cnt + 1'b1;
          if (w_line_done) begin
            r_line_cnt <= r_line_cnt + 1'b1;
            if (w_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_buf <= '0;
    end else begin
      for (int k = 0; k < WORDS_PER_LINE - 1; k++) begin
        if (w_accept && r_word_cnt == WORD_CNT_W'(k))
          r_line_buf[k*WORD_W +: WORD_W] <= DataIn_i;
      end
    end
  end
endmodule

// File: tb/tb_write_line_buffer.sv
// Scoreboard bench for write_line_buffer with a frame-level model.
module tb_write_line_buffer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         Start_i = 1'b0;
  logic [8:0]   FrameLines_i = '0;
  logic [63:0]  DataIn_i = '0;
  logic         DataValid_i = 1'b0;
  logic         WriteAck_i = 1'b0;
  logic         DataReady_o;
  logic [511:0] WriteBuffer_o;
  logic         WriteReq_o;
  logic         First_o;
  logic         Last_o;
  logic         Busy_o;

  int n_chk = 0;
  int n_fail = 0;
  int ack_mode = 2;
  int gap_max = 2;
  logic [513:0] sb[$];
  logic [63:0]  words[$];
  logic [513:0] exp_e;

  write_line_buffer #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .Start_i       (Start_i),
    .FrameLines_i  (FrameLines_i),
    .DataIn_i      (DataIn_i),
    .DataValid_i   (DataValid_i),
    .DataReady_o   (DataReady_o),
    .WriteBuffer_o (WriteBuffer_o),
    .WriteReq_o    (WriteReq_o),
    .WriteAck_i    (WriteAck_i),
    .First_o       (First_o),
    .Last_o        (Last_o),
    .Busy_o        (Busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [513:0] act,
                     input logic [513:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, 514'(DataReady_o), 514'(0));
    chk({nm, "_req"},   514'(WriteReq_o),  514'(0));
    chk({nm, "_first"}, 514'(First_o),     514'(0));
    chk({nm, "_last"},  514'(Last_o),      514'(0));
    chk({nm, "_busy"},  514'(Busy_o),      514'(0));
    chk({nm, "_buf"},   514'(WriteBuffer_o), 514'(0));
  endtask

  // Frame model: line i is words 8i..8i+7, tags from line index.
  task automatic build(input int n, input bit seq);
    logic [511:0] line;
    words.delete();
    for (int i = 0; i < n * 8; i++)
      words.push_back(seq ? 64'(i + 1) : {$urandom, $urandom});
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) line[64*k +: 64] = words[8*i + k];
      sb.push_back({(i == n - 1), (i == 0), line});
    end
  endtask

  task automatic start(input int n);
    Start_i = 1'b1;
    FrameLines_i = 9'(n);
    cyc();
    Start_i = 1'b0;
    FrameLines_i = 9'($urandom);
  endtask

  task automatic send_word(input logic [63:0] w);
    bit ok;
    bit r;
    ok = 1'b0;
    DataIn_i = w;
    DataValid_i = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      r = DataReady_o;
      cyc();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    DataValid_i = 1'b0;
    chk("word_accepted", 514'(ok), 514'(1));
    repeat ($urandom_range(0, gap_max)) cyc();
  endtask

  task automatic send(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_word(words[i]);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!Busy_o && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_drained", 514'(ok), 514'(1));
    cyc();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       WriteAck_i = ($urandom_range(0, 2) != 0);
        1:       WriteAck_i = 1'b1;
        default: WriteAck_i = 1'b0;
      endcase
    end
  end

  // Monitor: a line is consumed at the next edge when req & ack.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && WriteReq_o && WriteAck_i) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_line: got %h expected none",
                   {Last_o, First_o, WriteBuffer_o});
        end else begin
          exp_e = sb.pop_front();
          chk("line", {Last_o, First_o, WriteBuffer_o}, exp_e);
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) cyc();
    @(negedge clk);
    chk_zero("in_reset");
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_zero("after_reset");
    cyc();

    // Two-line sequential frame, master always ready.
    ack_mode = 1;
    build(2, 1'b1);
    start(2);
    send(0, 16);
    wait_idle();

    // Start with zero lines is ignored.
    Start_i = 1'b1;
    FrameLines_i = '0;
    cyc();
    Start_i = 1'b0;
    @(negedge clk);
    chk("zero_start_busy", 514'(Busy_o), 514'(0));
    chk("zero_start_ready", 514'(DataReady_o), 514'(0));
    cyc();

    // Start during RUN must not relatch the line count.
    ack_mode = 0;
    build(2, 1'b0);
    start(2);
    send(0, 3);
    Start_i = 1'b1;
    FrameLines_i = 9'd5;
    cyc();
    Start_i = 1'b0;
    @(negedge clk);
    chk("run_start_busy", 514'(Busy_o), 514'(1));
    cyc();
    send(3, 16);
    wait_idle();

    // Backpressure: four lines queued, word 7 of line 4 stalls.
    ack_mode = 2;
    build(6, 1'b0);
    start(6);
    send(0, 39);
    DataIn_i = words[39];
    DataValid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready_low", 514'(DataReady_o), 514'(0));
      chk("full_req_high", 514'(WriteReq_o), 514'(1));
      cyc();
    end
    DataValid_i = 1'b0;
    ack_mode = 0;
    send(39, 48);
    wait_idle();

    // Single-line frame and Busy release timing.
    ack_mode = 1;
    gap_max = 0;
    build(1, 1'b0);
    start(1);
    send(0, 8);
    @(negedge clk);
    chk("single_req", 514'(WriteReq_o), 514'(1));
    chk("single_busy0", 514'(Busy_o), 514'(1));
    @(negedge clk);
    chk("single_req_gone", 514'(WriteReq_o), 514'(0));
    chk("single_busy1", 514'(Busy_o), 514'(1));
    @(negedge clk);
    chk("single_busy2", 514'(Busy_o), 514'(0));
    cyc();
    gap_max = 2;

    // Reset mid-frame discards queued and partial lines.
    ack_mode = 2;
    build(8, 1'b0);
    start(8);
    send(0, 27);
    rst = 1'b1;
    sb.delete();
    cyc();
    @(negedge clk);
    chk_zero("mid_reset");
    cyc();
    rst = 1'b0;
    ack_mode = 1;
    build(3, 1'b0);
    start(3);
    send(0, 7);
    @(negedge clk);
    chk("post_reset_no_req", 514'(WriteReq_o), 514'(0));
    cyc();
    send(7, 24);
    wait_idle();

    // Random frames with random valid gaps and ack.
    ack_mode = 0;
    repeat (6) begin
      n = $urandom_range(1, 9);
      build(n, 1'b0);
      start(n);
      send(0, n * 8);
      wait_idle();
    end

    chk("scoreboard_empty", 514'(sb.size()), 514'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
